// File: rtl/snd_rcv_splitter.sv
// snd_rcv_splitter
//   Receive-side inverse of the snd/rcv aggregator. Takes one M*N-bit word per
//   valid/ready handshake and replays it as M consecutive N-bit beats, most
//   significant slice first. A one-word staging register behind the shift
//   register lets back-to-back wide words stream without bubbles.
//
// Parameters
//   N  width of one output beat (N >= 1)
//   M  beats per input word (M >= 1); input width is M*N
//
// Ports
//   clk       clock, all logic on posedge
//   rst       asynchronous, active-high reset
//   vld_in    input word valid
//   data_in   input word; bits [M*N-1 -: N] form beat 0
//   rdy_out   splitter can accept a word this cycle
//   vld_out   output beat valid
//   data_out  output beat
//   rdy_in    downstream accepts beat this cycle
//   last_out  final beat of a word (present only when SNDRCV_SPLIT_LAST_EN is defined)
//
// Build option
//   SNDRCV_SPLIT_LAST_EN  adds the last_out port and its flop.

module snd_rcv_splitter #(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vld_in,
  input  logic [M*N-1:0] data_in,
  output logic           rdy_out,
  output logic           vld_out,
  output logic [N-1:0]   data_out,
  input  logic           rdy_in
`ifdef SNDRCV_SPLIT_LAST_EN
  ,
  output logic           last_out
`endif
);

  localparam int W  = M * N;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0]  sh,     sh_nx;
  logic          sh_vld, sh_vld_nx;
  logic [CW-1:0] cnt,    cnt_nx;
  logic [W-1:0]  stg,    stg_nx;
  logic          stg_vld, stg_vld_nx;

  logic acc;
  logic emit;
  logic last_beat;

  // Readiness depends only on the staging flop (and reset), never on rdy_in/vld_in.
  assign rdy_out   = ~stg_vld & ~rst;
  assign acc       = vld_in & rdy_out;
  assign emit      = sh_vld & rdy_in;
  assign last_beat = (cnt == CW'(M - 1));

  assign vld_out  = sh_vld;
  assign data_out = sh[W-1 -: N];

  always_comb begin
    sh_nx      = sh;
    sh_vld_nx  = sh_vld;
    cnt_nx     = cnt;
    stg_nx     = stg;
    stg_vld_nx = stg_vld;

    if (emit) begin
      if (!last_beat) begin
        sh_nx  = sh << N;
        cnt_nx = cnt + CW'(1);
      end else begin
        // Last beat leaves: refill from staging first, else straight from the
        // input, else go idle. acc and stg_vld are mutually exclusive here.
        cnt_nx = '0;
        if (stg_vld) begin
          sh_nx      = stg;
          stg_vld_nx = 1'b0;
        end else if (acc) begin
          sh_nx = data_in;
        end else begin
          sh_vld_nx = 1'b0;
        end
      end
    end else if (!sh_vld && acc) begin
      sh_nx     = data_in;
      sh_vld_nx = 1'b1;
      cnt_nx    = '0;
    end

    // A word arriving while the shifter is busy (and not draining its last
    // beat this cycle) parks in staging.
    if (sh_vld && acc && !(emit && last_beat)) begin
      stg_nx     = data_in;
      stg_vld_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      sh_vld  <= 1'b0;
      cnt     <= '0;
      stg     <= '0;
      stg_vld <= 1'b0;
    end else begin
      sh      <= sh_nx;
      sh_vld  <= sh_vld_nx;
      cnt     <= cnt_nx;
      stg     <= stg_nx;
      stg_vld <= stg_vld_nx;
    end
  end

`ifdef SNDRCV_SPLIT_LAST_EN
  // Registered from the next-state values so last_out comes straight from a
  // flop, aligned with data_out.
  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= sh_vld_nx & (cnt_nx == CW'(M - 1));
    end
  end

  assign last_out = last_q;
`endif

endmodule

// File: tb/tb_snd_rcv_splitter.sv
// tb_snd_rcv_splitter
//   Bench for snd_rcv_splitter: a directed vector table (N=4, M=2), hand-written
//   reset-mid-word and M=1 sequences, and a randomized run checked against a
//   beat-queue reference model.

module tb_snd_rcv_splitter;

  localparam int TN  = 4;
  localparam int TM  = 2;
  localparam int TN1 = 8;
  localparam int TM1 = 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;

  logic                vld_in = 1'b0;
  logic [TM*TN-1:0]    data_in = '0;
  logic                rdy_in = 1'b0;
  logic                rdy_out, vld_out;
  logic [TN-1:0]       data_out;
  logic                last_out;

  logic                vld_in1 = 1'b0;
  logic [TM1*TN1-1:0]  data_in1 = '0;
  logic                rdy_in1 = 1'b0;
  logic                rdy_out1, vld_out1;
  logic [TN1-1:0]      data_out1;
  logic                last_out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snd_rcv_splitter #(.N(TN), .M(TM)) dut (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (vld_in),
    .data_in  (data_in),
    .rdy_out  (rdy_out),
    .vld_out  (vld_out),
    .data_out (data_out),
    .rdy_in   (rdy_in)
`ifdef SNDRCV_SPLIT_LAST_EN
    ,
    .last_out (last_out)
`endif
  );

  snd_rcv_splitter #(.N(TN1), .M(TM1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (vld_in1),
    .data_in  (data_in1),
    .rdy_out  (rdy_out1),
    .vld_out  (vld_out1),
    .data_out (data_out1),
    .rdy_in   (rdy_in1)
`ifdef SNDRCV_SPLIT_LAST_EN
    ,
    .last_out (last_out1)
`endif
  );

`ifndef SNDRCV_SPLIT_LAST_EN
  assign last_out  = 1'b0;
  assign last_out1 = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_last(input string name, input logic act, input logic exp);
`ifdef SNDRCV_SPLIT_LAST_EN
    chk(name, {31'd0, act}, {31'd0, exp});
`else
    if (act !== exp) $display("note: %s unused without last_out", name);
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       vi;
    logic [7:0] di;
    logic       ri;
    logic       ev;
    logic [3:0] ed;
    logic       er;
    logic       el;
  } vec_t;

  typedef struct {
    logic [TN-1:0] d;
    logic          l;
  } beat_t;

  vec_t  vt[$];
  beat_t q[$];

  task automatic add(input logic vi, input logic [7:0] di, input logic ri,
                     input logic ev, input logic [3:0] ed, input logic er, input logic el);
    vec_t v;
    v.vi = vi; v.di = di; v.ri = ri; v.ev = ev; v.ed = ed; v.er = er; v.el = el;
    vt.push_back(v);
  endtask

  initial begin
    // Expected outputs in each row are those seen during that cycle, before its edge.
    // Single word A5
    add(1, 8'hA5, 1, 0, 4'h0, 1, 0);
    add(0, 8'h00, 1, 1, 4'hA, 1, 0);
    add(0, 8'h00, 1, 1, 4'h5, 1, 1);
    add(0, 8'h00, 1, 0, 4'h0, 1, 0);
    // 12,34,56 offered back-to-back, downstream always ready
    add(1, 8'h12, 1, 0, 4'h0, 1, 0);
    add(1, 8'h34, 1, 1, 4'h1, 1, 0);
    add(1, 8'h56, 1, 1, 4'h2, 0, 1);
    add(1, 8'h56, 1, 1, 4'h3, 1, 0);
    add(0, 8'h00, 1, 1, 4'h4, 0, 1);
    add(0, 8'h00, 1, 1, 4'h5, 1, 0);
    add(0, 8'h00, 1, 1, 4'h6, 1, 1);
    add(0, 8'h00, 1, 0, 4'h0, 1, 0);
    // Stalled downstream fills both registers, then drains
    add(1, 8'h12, 0, 0, 4'h0, 1, 0);
    add(1, 8'h34, 0, 1, 4'h1, 1, 0);
    add(1, 8'h56, 0, 1, 4'h1, 0, 0);
    add(1, 8'h56, 0, 1, 4'h1, 0, 0);
    add(1, 8'h56, 1, 1, 4'h1, 0, 0);
    add(1, 8'h56, 1, 1, 4'h2, 0, 1);
    add(1, 8'h56, 1, 1, 4'h3, 1, 0);
    add(0, 8'h00, 1, 1, 4'h4, 0, 1);
    add(0, 8'h00, 1, 1, 4'h5, 1, 0);
    add(0, 8'h00, 1, 1, 4'h6, 1, 1);
    add(0, 8'h00, 1, 0, 4'h0, 1, 0);

    // Reset state
    #1;
    chk("reset vld_out", {31'd0, vld_out}, 32'd0);
    chk("reset data_out", {28'd0, data_out}, 32'd0);
    chk("reset rdy_out", {31'd0, rdy_out}, 32'd0);
    chk_last("reset last_out", last_out, 1'b0);
    chk("reset vld_out1", {31'd0, vld_out1}, 32'd0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("post-reset rdy_out", {31'd0, rdy_out}, 32'd1);
    tick;

    // Directed vector table
    foreach (vt[i]) begin
      vld_in  = vt[i].vi;
      data_in = vt[i].di;
      rdy_in  = vt[i].ri;
      chk($sformatf("vec%0d vld_out", i), {31'd0, vld_out}, {31'd0, vt[i].ev});
      chk($sformatf("vec%0d rdy_out", i), {31'd0, rdy_out}, {31'd0, vt[i].er});
      if (vt[i].ev)
        chk($sformatf("vec%0d data_out", i), {28'd0, data_out}, {28'd0, vt[i].ed});
      chk_last($sformatf("vec%0d last_out", i), last_out, vt[i].el);
      tick;
    end

    // Reset in the middle of a word discards the remaining beat
    vld_in = 1'b1; data_in = 8'h12; rdy_in = 1'b1;
    tick;
    vld_in = 1'b0; data_in = '0;
    chk("rstmid beat0", {28'd0, data_out}, 32'h1);
    tick;
    chk("rstmid beat1 pending", {28'd0, data_out}, 32'h2);
    rst = 1'b1;
    #1;
    chk("rstmid vld_out async", {31'd0, vld_out}, 32'd0);
    chk("rstmid rdy_out in reset", {31'd0, rdy_out}, 32'd0);
    tick;
    #2;
    rst = 1'b0;
    tick;
    chk("rstmid rdy_out after", {31'd0, rdy_out}, 32'd1);
    for (int unsigned k = 0; k < 3; k++) begin
      chk($sformatf("rstmid idle%0d vld_out", k), {31'd0, vld_out}, 32'd0);
      tick;
    end

    // M=1, N=8: two-deep registered pass-through
    rdy_in1 = 1'b1; vld_in1 = 1'b1; data_in1 = 8'h01;
    chk("m1 rdy0", {31'd0, rdy_out1}, 32'd1);
    chk("m1 idle vld", {31'd0, vld_out1}, 32'd0);
    tick;
    data_in1 = 8'h02;
    chk("m1 w0 vld", {31'd0, vld_out1}, 32'd1);
    chk("m1 w0 data", {24'd0, data_out1}, 32'h01);
    chk_last("m1 w0 last", last_out1, 1'b1);
    tick;
    vld_in1 = 1'b0; rdy_in1 = 1'b0;
    chk("m1 w1 data", {24'd0, data_out1}, 32'h02);
    tick;
    // Fill both registers while stalled
    vld_in1 = 1'b1; data_in1 = 8'h03;
    chk("m1 stall hold", {24'd0, data_out1}, 32'h02);
    chk("m1 stall rdy", {31'd0, rdy_out1}, 32'd0 | 32'd1);
    tick;
    data_in1 = 8'h04;
    chk("m1 full rdy", {31'd0, rdy_out1}, 32'd0);
    tick;
    rdy_in1 = 1'b1;
    chk("m1 full hold", {24'd0, data_out1}, 32'h02);
    tick;
    chk("m1 drain w3", {24'd0, data_out1}, 32'h03);
    chk("m1 drain rdy", {31'd0, rdy_out1}, 32'd1);
    tick;
    vld_in1 = 1'b0;
    chk("m1 drain w4", {24'd0, data_out1}, 32'h04);
    tick;
    chk("m1 end vld", {31'd0, vld_out1}, 32'd0);

    // Randomized traffic against a beat-queue model
    begin
      logic       pend;
      logic       mrdy;
      logic       memit;
      logic [7:0] w;
      pend = 1'b0;
      w    = '0;
      q.delete();
      for (int unsigned c = 0; c < 3000; c++) begin
        mrdy = (q.size() <= TM);
        chk("rand vld_out", {31'd0, vld_out}, {31'd0, (q.size() > 0)});
        chk("rand rdy_out", {31'd0, rdy_out}, {31'd0, mrdy});
        if (q.size() > 0) begin
          chk("rand data_out", {28'd0, data_out}, {28'd0, q[0].d});
          chk_last("rand last_out", last_out, q[0].l);
        end
        if (!pend) begin
          w = 8'($urandom);
          vld_in = ($urandom_range(0, 2) != 0);
        end
        data_in = w;
        rdy_in  = ($urandom_range(0, 3) != 0);
        memit = (q.size() > 0) && rdy_in;
        if (memit) void'(q.pop_front());
        if (vld_in && mrdy) begin
          for (int b = 0; b < TM; b++) begin
            beat_t bt;
            bt.d = TN'(w >> ((TM - 1 - b) * TN));
            bt.l = (b == TM - 1);
            q.push_back(bt);
          end
        end
        pend = vld_in && !mrdy;
        tick;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
